rcc_domain_stop_seq: RTL and testbench

//  Sequences low-power stop entry/exit for one power domain (instantiated per D1/D2/D3).

---
 rtl/rcc_domain_stop_seq.sv | 172 +++++++++++++++++
 tb/tb_rcc_domain_stop_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_domain_stop_seq.sv
// rtl/rcc_domain_stop_seq.sv - low-power stop entry/exit sequencer for one power domain
//
// Drains the domain bus, gates the domain clock, then raises the stop request to PWR.
// On PWR wakeup it drops the request and re-enables the clock after CLK_ON_DELAY cycles.
//
// Optional feature macro: RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN (DRAIN timeout + sticky flag).
//
// Ports:
//   clk            in   domain sequencing clock
//   rst_n          in   synchronous active-low reset
//   stop_cond      in   domain stop qualifier
//   bus_busy       in   OR of domain bridge/flash busy flags
//   pwr_wkup       in   PWR wakeup level for this domain
//   pwr_req        out  stop request to PWR (registered)
//   clk_en         out  domain clock-gate enable (registered)
//   stopped        out  domain in stop, request outstanding (registered)
//   drain_timeout  out  sticky DRAIN-timeout flag (timeout builds only)
//   timeout_clr    in   clears drain_timeout (timeout builds only)
module rcc_domain_stop_seq #(
    parameter int IDLE_STABLE_CYCLES = 4,
    parameter int GATE_SETTLE        = 2,
    parameter int CLK_ON_DELAY       = 8
`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
    ,
    parameter int DRAIN_TIMEOUT      = 1024
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stop_cond,
    input  logic bus_busy,
    input  logic pwr_wkup,
    output logic pwr_req,
    output logic clk_en,
    output logic stopped
`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
    ,
    output logic drain_timeout,
    input  logic timeout_clr
`endif
);

    localparam int CNT_MAX_A = (IDLE_STABLE_CYCLES > GATE_SETTLE) ? IDLE_STABLE_CYCLES : GATE_SETTLE;
    localparam int CNT_MAX   = (CNT_MAX_A > CLK_ON_DELAY) ? CNT_MAX_A : CLK_ON_DELAY;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(GATE_SETTLE - 1);
    localparam logic [CW-1:0] CLKON_LAST  = CW'(CLK_ON_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_GATE    = 3'd2,
        S_REQ     = 3'd3,
        S_RESTORE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pwr_req_d, clk_en_d, stopped_d;
    logic          entry_block;

`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
    localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [TW-1:0] TMR_LAST = TW'(DRAIN_TIMEOUT - 1);

    logic [TW-1:0] tmr_q;
    logic          tmo_set;

    // A pending timeout flag keeps the domain out of DRAIN until software clears it.
    assign entry_block = drain_timeout;
`else
    assign entry_block = 1'b0;
`endif

    // State register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pwr_req <= 1'b0;
            clk_en  <= 1'b1;
            stopped <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwr_req <= pwr_req_d;
            clk_en  <= clk_en_d;
            stopped <= stopped_d;
        end
    end

`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
    // Timer sits at zero outside DRAIN, so it restarts on every DRAIN entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q         <= '0;
            drain_timeout <= 1'b0;
        end else begin
            tmr_q <= (state_q == S_DRAIN && state_d == S_DRAIN) ? tmr_q + TMR_ONE : '0;
            if (tmo_set)
                drain_timeout <= 1'b1;
            else if (timeout_clr)
                drain_timeout <= 1'b0;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
        tmo_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (stop_cond && !pwr_wkup && !entry_block)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!stop_cond) begin
                    state_d = S_IDLE;
                end else if (!bus_busy && cnt_q == IDLE_LAST) begin
                    state_d = S_GATE;
                end else begin
                    cnt_d = bus_busy ? '0 : cnt_q + CNT_ONE;
`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
                    // Reaching GATE this cycle takes precedence over giving up.
                    if (tmr_q == TMR_LAST) begin
                        state_d = S_IDLE;
                        tmo_set = 1'b1;
                    end
`endif
                end
            end
            S_GATE: begin
                // Abort before the request is raised: clock still has to be restored safely.
                if (!stop_cond || bus_busy)
                    state_d = S_RESTORE;
                else if (cnt_q == SETTLE_LAST)
                    state_d = S_REQ;
                else
                    cnt_d = cnt_q + CNT_ONE;
            end
            S_REQ: begin
                if (pwr_wkup)
                    state_d = S_RESTORE;
            end
            S_RESTORE: begin
                if (cnt_q == CLKON_LAST)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q)
            cnt_d = '0;
    end

    // Output logic, decoded from the next state so outputs change on the transition edge.
    always_comb begin
        pwr_req_d = (state_d == S_REQ);
        stopped_d = (state_d == S_REQ);
        clk_en_d  = (state_d == S_IDLE) || (state_d == S_DRAIN);
    end

endmodule

// File: tb/tb_rcc_domain_stop_seq.sv
// tb/tb_rcc_domain_stop_seq.sv - self-checking bench for rcc_domain_stop_seq
module tb_rcc_domain_stop_seq;

    localparam int ISC = 4;
    localparam int GS  = 2;
    localparam int COD = 8;
    localparam int DT  = 16;

    logic clk;
    logic rst_n;
    logic stop_cond;
    logic bus_busy;
    logic pwr_wkup;
    logic pwr_req;
    logic clk_en;
    logic stopped;
    logic timeout_clr;
`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
    logic drain_timeout;
`endif

    int n_assert;
    int n_fail;

`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
    rcc_domain_stop_seq #(
        .IDLE_STABLE_CYCLES(ISC),
        .GATE_SETTLE       (GS),
        .CLK_ON_DELAY      (COD),
        .DRAIN_TIMEOUT     (DT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stop_cond    (stop_cond),
        .bus_busy     (bus_busy),
        .pwr_wkup     (pwr_wkup),
        .pwr_req      (pwr_req),
        .clk_en       (clk_en),
        .stopped      (stopped),
        .drain_timeout(drain_timeout),
        .timeout_clr  (timeout_clr)
    );
    localparam bit TMO_EN = 1'b1;
`else
    rcc_domain_stop_seq #(
        .IDLE_STABLE_CYCLES(ISC),
        .GATE_SETTLE       (GS),
        .CLK_ON_DELAY      (COD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stop_cond(stop_cond),
        .bus_busy (bus_busy),
        .pwr_wkup (pwr_wkup),
        .pwr_req  (pwr_req),
        .clk_en   (clk_en),
        .stopped  (stopped)
    );
    localparam bit TMO_EN = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase of the stop sequence plus a count of qualifying samples
    // seen in the current phase.
    typedef enum {P_IDLE, P_DRAIN, P_GATE, P_REQ, P_RESTORE} phase_t;
    phase_t m_ph;
    int     m_run;    // consecutive bus-idle samples (DRAIN) or samples spent (GATE/RESTORE)
    int     m_dsamp;  // samples spent in DRAIN since entry
    logic   m_tmo;

    function automatic logic exp_clk_en();
        return (m_ph == P_IDLE) || (m_ph == P_DRAIN);
    endfunction

    function automatic logic exp_req();
        return (m_ph == P_REQ);
    endfunction

    task automatic model_edge();
        logic set_tmo;
        set_tmo = 1'b0;
        if (!rst_n) begin
            m_ph = P_IDLE; m_run = 0; m_dsamp = 0; m_tmo = 1'b0;
            return;
        end
        case (m_ph)
            P_IDLE: if (stop_cond && !pwr_wkup && !m_tmo) begin
                m_ph = P_DRAIN; m_run = 0; m_dsamp = 0;
            end
            P_DRAIN: begin
                if (!stop_cond) m_ph = P_IDLE;
                else begin
                    m_dsamp++;
                    m_run = bus_busy ? 0 : m_run + 1;
                    if (m_run == ISC) begin
                        m_ph = P_GATE; m_run = 0;
                    end else if (TMO_EN && m_dsamp == DT) begin
                        m_ph = P_IDLE; set_tmo = 1'b1;
                    end
                end
            end
            P_GATE: begin
                if (!stop_cond || bus_busy) begin
                    m_ph = P_RESTORE; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == GS) begin m_ph = P_REQ; m_run = 0; end
                end
            end
            P_REQ: if (pwr_wkup) begin m_ph = P_RESTORE; m_run = 0; end
            P_RESTORE: begin
                m_run++;
                if (m_run == COD) begin m_ph = P_IDLE; m_run = 0; end
            end
            default: m_ph = P_IDLE;
        endcase
        if (TMO_EN) begin
            if (set_tmo) m_tmo = 1'b1;
            else if (timeout_clr) m_tmo = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("pwr_req", pwr_req, exp_req());
        chk("stopped", stopped, exp_req());
        chk("clk_en", clk_en, exp_clk_en());
        chk("req_implies_gated", pwr_req & clk_en, 1'b0);
`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
        chk("drain_timeout", drain_timeout, m_tmo);
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        m_ph = P_IDLE; m_run = 0; m_dsamp = 0; m_tmo = 1'b0;
        rst_n = 1'b0; stop_cond = 1'b0; bus_busy = 1'b0; pwr_wkup = 1'b0; timeout_clr = 1'b0;

        // Reset state
        ticks(2);
        chk("reset_clk_en", clk_en, 1'b1);
        chk("reset_pwr_req", pwr_req, 1'b0);
        chk("reset_stopped", stopped, 1'b0);

        // Stop entry and wakeup latency, bus idle throughout (edge numbers relative to e0)
        rst_n = 1'b1;
        tick();                                // e0
        stop_cond = 1'b1;
        ticks(4);                              // e1..e4
        chk("entry_clk_en_e4", clk_en, 1'b1);
        tick();                                // e5
        chk("entry_clk_en_e5", clk_en, 1'b0);
        tick();                                // e6
        chk("entry_req_e6", pwr_req, 1'b0);
        tick();                                // e7
        chk("entry_req_e7", pwr_req, 1'b1);
        chk("entry_stopped_e7", stopped, 1'b1);
        ticks(12);                             // e8..e19
        pwr_wkup = 1'b1;
        tick();                                // e20
        chk("wkup_req_e20", pwr_req, 1'b0);
        pwr_wkup = 1'b0; stop_cond = 1'b0;
        ticks(7);                              // e21..e27
        chk("wkup_clk_en_e27", clk_en, 1'b0);
        tick();                                // e28
        chk("wkup_clk_en_e28", clk_en, 1'b1);
        ticks(3);

        // bus_busy pulses at DRAIN cycles 2 and 5
        stop_cond = 1'b1;
        tick();                                // DRAIN entry
        ticks(2);
        bus_busy = 1'b1; tick(); bus_busy = 1'b0;
        ticks(2);
        bus_busy = 1'b1; tick(); bus_busy = 1'b0;
        ticks(3);
        chk("busy_clk_en_before", clk_en, 1'b1);
        tick();
        chk("busy_clk_en_after", clk_en, 1'b0);
        stop_cond = 1'b0;
        ticks(COD + 3);
        chk("busy_recovered", clk_en, 1'b1);

        // stop_cond drops one cycle into GATE
        stop_cond = 1'b1;
        ticks(1 + ISC);
        chk("abort_gated", clk_en, 1'b0);
        tick();
        stop_cond = 1'b0;
        tick();                                // GATE -> RESTORE
        chk("abort_no_req", pwr_req, 1'b0);
        ticks(COD - 1);
        chk("abort_clk_en_held", clk_en, 1'b0);
        tick();
        chk("abort_clk_en_back", clk_en, 1'b1);
        ticks(2);

        // pwr_wkup blocks entry from IDLE
        stop_cond = 1'b1; pwr_wkup = 1'b1;
        ticks(10);
        chk("blocked_clk_en", clk_en, 1'b1);
        chk("blocked_req", pwr_req, 1'b0);
        stop_cond = 1'b0; pwr_wkup = 1'b0;
        tick();

        // Reset while in REQ
        stop_cond = 1'b1;
        ticks(1 + ISC + GS);
        chk("req_before_reset", pwr_req, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rst_req", pwr_req, 1'b0);
        chk("rst_stopped", stopped, 1'b0);
        chk("rst_clk_en", clk_en, 1'b1);
        rst_n = 1'b1; stop_cond = 1'b0;
        ticks(2);

`ifdef RCC_DOMAIN_STOP_SEQ_TIMEOUT_EN
        // DRAIN timeout with bus stuck busy
        stop_cond = 1'b1; bus_busy = 1'b1;
        tick();                                // DRAIN entry
        ticks(DT - 1);
        chk("tmo_not_yet", drain_timeout, 1'b0);
        tick();
        chk("tmo_set", drain_timeout, 1'b1);
        bus_busy = 1'b0;
        ticks(ISC + 6);
        chk("tmo_no_reentry", clk_en, 1'b1);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        chk("tmo_cleared", drain_timeout, 1'b0);
        ticks(1 + ISC);
        chk("tmo_reentry_gates", clk_en, 1'b0);
        stop_cond = 1'b0;
        ticks(COD + 2);
`endif

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) stop_cond = ~stop_cond;
            bus_busy    = ($urandom_range(3) == 0);
            pwr_wkup    = ($urandom_range(9) == 0);
            rst_n       = ($urandom_range(299) != 0);
            timeout_clr = ($urandom_range(40) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
